// File: rtl/pipeid_hzd_if.sv
// Decode-stage hazard bus: IF/ID operands, EX/MEM/WB bypass sources and ID/EX outputs.
// slave = pipeid_hzd side, master = the pipeline (or bench) that feeds it.
interface pipeid_hzd_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          id_valid;
  logic [RW-1:0] rs, rt;
  logic [DW-1:0] q1, q2;
  logic          use_rs, use_rt;
  logic [RW-1:0] drn;
  logic          dwreg, dm2reg, dmdu;
  logic          dbeq, dbne;
  logic [DW-1:0] dpc4, br_off;
  logic          ewreg, em2reg;
  logic [RW-1:0] ern;
  logic [DW-1:0] ealu;
  logic          mwreg, mm2reg;
  logic [RW-1:0] mrn;
  logic [DW-1:0] malu, mmo;
  logic          wwreg;
  logic [RW-1:0] wrn;
  logic [DW-1:0] wdi;
  logic          wpcir, taken, busy;
  logic [DW-1:0] bpc;
  logic          e_valid, e_wreg, e_m2reg, e_mdu;
  logic [RW-1:0] e_rn;
  logic [DW-1:0] e_a, e_b;
  logic          dbg_state;

  modport slave (
    input  id_valid, rs, rt, q1, q2, use_rs, use_rt, drn, dwreg, dm2reg, dmdu,
           dbeq, dbne, dpc4, br_off, ewreg, em2reg, ern, ealu,
           mwreg, mm2reg, mrn, malu, mmo, wwreg, wrn, wdi,
    output wpcir, taken, busy, bpc, e_valid, e_wreg, e_m2reg, e_mdu,
           e_rn, e_a, e_b, dbg_state
  );

  modport master (
    output id_valid, rs, rt, q1, q2, use_rs, use_rt, drn, dwreg, dm2reg, dmdu,
           dbeq, dbne, dpc4, br_off, ewreg, em2reg, ern, ealu,
           mwreg, mm2reg, mrn, malu, mmo, wwreg, wrn, wdi,
    input  wpcir, taken, busy, bpc, e_valid, e_wreg, e_m2reg, e_mdu,
           e_rn, e_a, e_b, dbg_state
  );
endinterface

// File: rtl/pipeid_hzd.sv
// ID stage: operand forwarding, load-use / MDU interlock, branch resolve, ID/EX register.
// Optional WB bypass level enabled by defining PIPEID_WB_BYPASS_EN.
module pipeid_hzd #(
  parameter int DW      = 32,
  parameter int RW      = 5,
  parameter int MDU_LAT = 4
) (
  input  logic        clock,
  input  logic        reset,
  pipeid_hzd_if.slave bus
);
  localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [DW-1:0] w_a, w_b;
  logic          w_busy, w_lu, w_stall, w_issue;

  logic          r_e_valid, r_e_wreg, r_e_m2reg, r_e_mdu;
  logic [RW-1:0] r_e_rn;
  logic [DW-1:0] r_e_a, r_e_b;

  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] src, input logic [DW-1:0] q);
    logic [DW-1:0] v;
    v = q;
    if (src == '0)
      v = '0;
    else if (bus.ewreg && !bus.em2reg && bus.ern == src)
      v = bus.ealu;
    else if (bus.mwreg && bus.mrn == src)
      v = bus.mm2reg ? bus.mmo : bus.malu;
`ifdef PIPEID_WB_BYPASS_EN
    else if (bus.wwreg && bus.wrn == src)
      v = bus.wdi;
`endif
    return v;
  endfunction

`ifndef PIPEID_WB_BYPASS_EN
  // WB data reaches us through the register file's negedge write instead.
  logic w_unused_wb;
  assign w_unused_wb = ^{bus.wwreg, bus.wrn, bus.wdi};
`endif

  assign w_a     = fwd(bus.rs, bus.q1);
  assign w_b     = fwd(bus.rt, bus.q2);
  assign w_busy  = (r_state == S_BUSY);
  assign w_lu    = bus.id_valid & bus.ewreg & bus.em2reg & (bus.ern != '0) &
                   ((bus.use_rs & (bus.ern == bus.rs)) | (bus.use_rt & (bus.ern == bus.rt)));
  assign w_stall = w_lu | (w_busy & bus.id_valid);
  assign w_issue = bus.id_valid & ~w_stall;

  // Counter holds remaining BUSY cycles; leaving at 1 gives MDU_LAT-1 busy cycles.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_issue && bus.dmdu && (MDU_LAT > 1)) begin
          w_state_nx = S_BUSY;
          w_cnt_nx   = CW'(MDU_LAT - 1);
        end
      end
      S_BUSY: begin
        if (r_cnt == CW'(1)) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // A bubble clears only the control flags; data fields keep their last value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_e_valid <= 1'b0;
      r_e_wreg  <= 1'b0;
      r_e_m2reg <= 1'b0;
      r_e_mdu   <= 1'b0;
      r_e_rn    <= '0;
      r_e_a     <= '0;
      r_e_b     <= '0;
    end else if (w_issue) begin
      r_e_valid <= 1'b1;
      r_e_wreg  <= bus.dwreg;
      r_e_m2reg <= bus.dm2reg;
      r_e_mdu   <= bus.dmdu;
      r_e_rn    <= bus.drn;
      r_e_a     <= w_a;
      r_e_b     <= w_b;
    end else begin
      r_e_valid <= 1'b0;
      r_e_wreg  <= 1'b0;
      r_e_m2reg <= 1'b0;
      r_e_mdu   <= 1'b0;
    end
  end

  assign bus.wpcir     = ~w_stall;
  assign bus.busy      = w_busy;
  assign bus.taken     = w_issue & ((bus.dbeq & (w_a == w_b)) | (bus.dbne & (w_a != w_b)));
  assign bus.bpc       = bus.dpc4 + bus.br_off;
  assign bus.e_valid   = r_e_valid;
  assign bus.e_wreg    = r_e_wreg;
  assign bus.e_m2reg   = r_e_m2reg;
  assign bus.e_mdu     = r_e_mdu;
  assign bus.e_rn      = r_e_rn;
  assign bus.e_a       = r_e_a;
  assign bus.e_b       = r_e_b;
  assign bus.dbg_state = r_state;
endmodule

// File: doc/pipeid_hzd.md
Name: pipeid_hzd

Overview:
- Parametrised successor to the decode stage for the pipelined CPU.
- Adds the following to the decode datapath:
  - operand forwarding with configurable width and register count;
  - load-use stall detection;
  - a multi-cycle (MDU) busy interlock driven by a down-counter state machine;
  - branch resolution in ID;
  - an integrated ID/EX pipeline register.
- Sits between the IF/ID register and the EX stage. Instruction decode (the cu block) and the register file stay outside this block and feed it.

Parameters:
DW, 32, datapath width
RW, 5, register address width (2**RW registers, register 0 hardwired zero)
MDU_LAT, 4, EX occupancy in cycles of a multi-cycle op (>=1)

Ports:
clock  in  1  system clock
reset  in  1  reset
id_valid  in  1  ID holds a real instruction
rs, rt  in  RW  source register numbers
q1, q2  in  DW  register file read data
use_rs, use_rt  in  1  instruction reads rs / rt
drn  in  RW  destination register
dwreg, dm2reg, dmdu  in  1  writes reg / is load / is multi-cycle op
dbeq, dbne  in  1  branch-if-equal / branch-if-not-equal
dpc4, br_off  in  DW  PC+4 and pre-shifted branch offset
ewreg, em2reg  in  1  EX-stage write / load flags
ern  in  RW  EX-stage destination
ealu  in  DW  EX-stage ALU result
mwreg, mm2reg  in  1  MEM-stage write / load flags
mrn  in  RW  MEM-stage destination
malu, mmo  in  DW  MEM-stage ALU result and memory data
wwreg  in  1  WB write enable
wrn  in  RW  WB destination
wdi  in  DW  WB data
wpcir  out  1  PC and IF/ID write enable (0 = stall)
taken  out  1  branch taken this cycle
bpc  out  DW  branch target
busy  out  1  MDU interlock active
e_valid, e_wreg, e_m2reg, e_mdu  out  1  ID/EX registered flags
e_rn  out  RW  ID/EX destination
e_a, e_b  out  DW  ID/EX forwarded operands

Behaviour:
- Interface: one clock, clock; reset is asynchronous and active-high (reset).
- Reset state:
  - all e_* outputs are 0;
  - FSM is IDLE and the counter is 0;
  - busy=0, so wpcir=1 and taken=0 unless the combinational conditions below hold.
- Forwarding, per operand (shown for rs; rt is the same with rt/q2):
  - src==0 gives 0.
  - Otherwise, ewreg & ~em2reg & ern==src gives ealu.
  - Otherwise, mwreg & mrn==src gives (mm2reg ? mmo : malu).
  - Otherwise, the WB level applies (optional feature).
  - Otherwise, q1.
  - EX has priority over MEM, and MEM over WB.
- Load-use condition: lu = id_valid & ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)).
- MDU FSM:
  - IDLE: an issue with dmdu=1 and MDU_LAT>1 loads cnt=MDU_LAT-1 and moves to BUSY.
  - BUSY: cnt decrements each cycle. When cnt reaches 1 the FSM returns to IDLE on the next edge, giving exactly MDU_LAT-1 BUSY cycles.
  - busy = (state==BUSY).
  - MDU_LAT=1: BUSY is never entered.
- Stall and issue:
  - stall = lu | (busy & id_valid); wpcir = ~stall.
  - lu and busy together produce a single stall; no double counting.
- ID/EX register, every clock edge:
  - When id_valid & ~stall: load the forwarded operands, e_rn=drn, the flags, and e_valid=1.
  - Otherwise: insert a bubble, with e_valid, e_wreg, e_m2reg and e_mdu all 0. Data fields hold their previous values.
- Branch:
  - taken = id_valid & ~stall & ((dbeq & a==b) | (dbne & a!=b)), where a and b are the forwarded operands.
  - A stall suppresses taken.
  - bpc = dpc4 + br_off modulo 2**DW; bpc is always driven.
- Reset mid-BUSY: returns the FSM to IDLE immediately and flushes the ID/EX register.

Optional Feature:
- Macro: PIPEID_WB_BYPASS_EN.
- Defined: adds a WB forwarding level, wwreg & wrn==src gives wdi, below MEM and above q1.
- Undefined: wwreg, wrn and wdi are ignored, and the register file's negedge write supplies WB data through q1/q2.

Test Plan:
1. Forwarding priority:
   - Stimulus: ern=mrn=rs=3 with ewreg=mwreg=1, em2reg=0, ealu=0x11, malu=0x22.
   - Response: e_a=0x11 after the edge; with ewreg=0, e_a=0x22.
2. Load-use stall:
   - Stimulus: ewreg=em2reg=1, ern=rt=5, use_rt=1.
   - Response: wpcir=0 and e_valid=0 for exactly one cycle. With mm2reg=1, mrn=5, mmo=0xABCD in the next cycle, e_b=0xABCD.
3. MDU interlock:
   - Stimulus: MDU_LAT=4, issue dmdu=1, then hold id_valid=1.
   - Response: busy=1 and wpcir=0 for 3 cycles, then the next instruction issues.
4. Branch:
   - Stimulus: dbeq=1, a=b=7, dpc4=0x100, br_off=0x20.
   - Response: taken=1, bpc=0x120. The same stimulus under load-use gives taken=0.
5. Wrap and reset:
   - Stimulus: dpc4=0xFFFFFFFC, br_off=8.
   - Response: bpc=0x4. Asserting reset while busy gives busy=0 and e_valid=0 with no clock edge.
6. Register 0:
   - Stimulus: rs=0, ern=0, ewreg=1, ealu=0x55.
   - Response: e_a=0. With PIPEID_WB_BYPASS_EN defined and wrn=rs=9, e_a=wdi.
